// File: rtl/cd_pkg.sv
// Shared constants and state encoding for the clock-divider limit control path.
package cd_pkg;
  localparam int CLK_MAX_WIDTH  = 32;
  localparam int CD_TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, COMMIT} cd_lim_state_t;
endpackage

// File: rtl/cd_timeout_cnt.sv
// Clear/enable counter with a terminal-count flag at TIMEOUT-1; bounds the wait for a divider edge.
module cd_timeout_cnt import cd_pkg::*; #(
  parameter int TIMEOUT = CD_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(TIMEOUT) + 1;
  localparam logic [W-1:0] TC_VAL = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + W'(1);
  end

  assign tc = (cnt == TC_VAL);
endmodule

// File: rtl/cd_limit_ctrl.sv
// Range-checks divider limit requests and commits them just after a divided-clock toggle, or on timeout.
// Optional build macro: CD_LIMIT_CLAMP_EN (clamp out-of-range requests instead of rejecting them).
module cd_limit_ctrl import cd_pkg::*; #(
  parameter int               WIDTH         = CLK_MAX_WIDTH,
  parameter logic [WIDTH-1:0] MIN_LIMIT     = WIDTH'(1),
  parameter logic [WIDTH-1:0] MAX_LIMIT     = '1,
  parameter logic [WIDTH-1:0] DEFAULT_LIMIT = WIDTH'(2),
  parameter int               TIMEOUT       = CD_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_limit,
  output logic             req_ready,
  input  logic             clkout_fb,
  output logic [WIDTH-1:0] limit,
  output logic             busy,
  output logic             upd_done,
  output logic             upd_forced,
  output logic             err
);
`ifdef CD_LIMIT_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  cd_lim_state_t    state;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] acc_val;
  logic             clkout_q, tog, tc, forced_q;
  logic             hs, under, over, in_range;

  // Bounds equal to the type limits are skipped so no always-true compare is built.
  generate
    if (MIN_LIMIT == '0) begin : g_no_min
      assign under = 1'b0;
    end else begin : g_min
      assign under = (req_limit < MIN_LIMIT);
    end
    if (MAX_LIMIT == '1) begin : g_no_max
      assign over = 1'b0;
    end else begin : g_max
      assign over = (req_limit > MAX_LIMIT);
    end
  endgenerate

  assign in_range = !under && !over;
  assign hs       = req_valid && req_ready;
  assign tog      = clkout_fb ^ clkout_q;
  // Only reaches shadow when in range, unless clamping is built in.
  assign acc_val  = under ? MIN_LIMIT : (over ? MAX_LIMIT : req_limit);

  cd_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != WAIT_EDGE),
    .en    (state == WAIT_EDGE),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shadow     <= '0;
      limit      <= DEFAULT_LIMIT;
      clkout_q   <= 1'b0;
      forced_q   <= 1'b0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      upd_done   <= 1'b0;
      upd_forced <= 1'b0;
      err        <= 1'b0;
    end else begin
      clkout_q   <= clkout_fb;
      upd_done   <= 1'b0;
      upd_forced <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: if (hs) begin
          err <= !in_range;
          if (in_range || CLAMP) begin
            shadow    <= acc_val;
            state     <= WAIT_EDGE;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        // A toggle wins over a simultaneous timeout.
        WAIT_EDGE: if (tog || tc) begin
          forced_q <= !tog;
          state    <= COMMIT;
        end
        COMMIT: begin
          limit      <= shadow;
          upd_done   <= 1'b1;
          upd_forced <= forced_q;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cd_limit_ctrl.sv
// Directed bench for cd_limit_ctrl: per-cycle vector table plus hand sequences for timeout, reject/clamp and reset.
module tb_cd_limit_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, clkout_fb, busy, upd_done, upd_forced, err;
  logic [31:0] req_limit, limit;
  logic        fbv;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  cd_limit_ctrl #(.WIDTH(32), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_limit  (req_limit),
    .req_ready  (req_ready),
    .clkout_fb  (clkout_fb),
    .limit      (limit),
    .busy       (busy),
    .upd_done   (upd_done),
    .upd_forced (upd_forced),
    .err        (err)
  );

  typedef struct {
    logic        v;
    logic [31:0] l;
    logic        fb;
    logic [31:0] elim;
    logic        erdy, ebusy, edone, eforced, eerr;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic v, input logic [31:0] l, input logic fb,
                              input logic [31:0] elim, input logic erdy, ebusy, edone, eforced, eerr);
    vec_t x;
    x.v = v; x.l = l; x.fb = fb; x.elim = elim;
    x.erdy = erdy; x.ebusy = ebusy; x.edone = edone; x.eforced = eforced; x.eerr = eerr;
    tbl.push_back(x);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] elim,
                         input logic erdy, ebusy, edone, eforced, eerr);
    chk({tag, ".limit"}, limit, elim);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(erdy));
    chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
    chk({tag, ".upd_done"}, 32'(upd_done), 32'(edone));
    chk({tag, ".upd_forced"}, 32'(upd_forced), 32'(eforced));
    chk({tag, ".err"}, 32'(err), 32'(eerr));
  endtask

  // Drive one cycle's inputs, then land 1 time unit after the next rising edge.
  task automatic tick(input logic v, input logic [31:0] l, input logic fb);
    req_valid = v; req_limit = l; clkout_fb = fb;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //   v  lim fb  elim rdy busy done frc err
    add(0,  0, 0,   2, 1, 0, 0, 0, 0);   // idle after reset
    add(0,  0, 0,   2, 1, 0, 0, 0, 0);
    add(1, 10, 0,   2, 1, 0, 0, 0, 0);   // T: accept 10
    add(0,  0, 0,   2, 0, 1, 0, 0, 0);
    add(0,  0, 0,   2, 0, 1, 0, 0, 0);
    add(0,  0, 0,   2, 0, 1, 0, 0, 0);
    add(0,  0, 1,   2, 0, 1, 0, 0, 0);   // T+4 toggle
    add(0,  0, 1,   2, 0, 1, 0, 0, 0);   // COMMIT
    add(0,  0, 1,  10, 1, 0, 1, 0, 0);   // T+6 new limit
    add(0,  0, 1,  10, 1, 0, 0, 0, 0);
    add(1,  7, 1,  10, 1, 0, 0, 0, 0);   // back-to-back: 7 accepted
    add(1,  9, 1,  10, 0, 1, 0, 0, 0);   // 9 held off
    add(1,  9, 0,  10, 0, 1, 0, 0, 0);   // toggle
    add(1,  9, 0,  10, 0, 1, 0, 0, 0);
    add(1,  9, 0,   7, 1, 0, 1, 0, 0);   // 9 accepted here
    add(0,  0, 0,   7, 0, 1, 0, 0, 0);
    add(0,  0, 1,   7, 0, 1, 0, 0, 0);   // toggle
    add(0,  0, 1,   7, 0, 1, 0, 0, 0);
    add(0,  0, 1,   9, 1, 0, 1, 0, 0);
    add(0,  0, 1,   9, 1, 0, 0, 0, 0);
    add(1,  1, 1,   9, 1, 0, 0, 0, 0);   // MIN_LIMIT, min latency
    add(0,  0, 0,   9, 0, 1, 0, 0, 0);   // toggle at T+1
    add(0,  0, 0,   9, 0, 1, 0, 0, 0);
    add(0,  0, 0,   1, 1, 0, 1, 0, 0);   // T+3
    add(0,  0, 0,   1, 1, 0, 0, 0, 0);
    add(1,  1, 0,   1, 1, 0, 0, 0, 0);   // same value again
    add(0,  0, 1,   1, 0, 1, 0, 0, 0);
    add(0,  0, 1,   1, 0, 1, 0, 0, 0);
    add(0,  0, 1,   1, 1, 0, 1, 0, 0);

    rst_n = 1'b0; req_valid = 1'b0; req_limit = '0; clkout_fb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 2, 1, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      chk_out($sformatf("vec%0d", i), tbl[i].elim, tbl[i].erdy, tbl[i].ebusy,
              tbl[i].edone, tbl[i].eforced, tbl[i].eerr);
      tick(tbl[i].v, tbl[i].l, tbl[i].fb);
    end

    // Stalled divider: request 5 commits by timeout at T+10.
    tick(0, 0, 0);
    chk("to.ready", 32'(req_ready), 1);
    tick(1, 5, 0);
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("to.busy@T+%0d", k), 32'(busy), 1);
      chk($sformatf("to.done@T+%0d", k), 32'(upd_done), 0);
      chk($sformatf("to.limit@T+%0d", k), limit, 1);
      tick(0, 0, 0);
    end
    chk_out("to.T+10", 5, 1, 0, 1, 1, 0);

    // Toggle in the same cycle as the terminal count: not a forced commit.
    tick(1, 6, 0);
    for (int k = 1; k <= 7; k++) tick(0, 0, 0);
    tick(0, 0, 1);
    chk("both.commit_busy", 32'(busy), 1);
    tick(0, 0, 1);
    chk_out("both.T+10", 6, 1, 0, 1, 0, 0);

    // Out-of-range request (0).
    tick(1, 0, 1);
    chk("rej.err", 32'(err), 1);
`ifdef CD_LIMIT_CLAMP_EN
    chk("clamp.busy", 32'(busy), 1);
    begin
      int k;
      for (k = 0; k < 20 && !upd_done; k++) tick(0, 0, 0);
    end
    chk("clamp.done", 32'(upd_done), 1);
    chk("clamp.limit", limit, 1);
    fbv = 1'b0;
`else
    chk("rej.ready", 32'(req_ready), 1);
    chk("rej.limit", limit, 6);
    tick(0, 0, 1);
    chk_out("rej.after", 6, 1, 0, 0, 0, 0);
    fbv = 1'b1;
`endif

    // Reset during WAIT_EDGE: pending 12 must be discarded.
    tick(1, 12, fbv);
    chk("rst.wait_busy", 32'(busy), 1);
    tick(0, 0, fbv);
    #2 rst_n = 1'b0;
    #1;
    chk_out("rst.async", 2, 1, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      fbv = ~fbv;
      tick(0, 0, fbv);
      chk($sformatf("rst.no_done%0d", k), 32'(upd_done), 0);
      chk($sformatf("rst.limit%0d", k), limit, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
